float_div_iter: RTL and testbench

- IEEE-754 single-precision divider: output_z = input_a / input_b. It is the inverse-operation companion to the pipelined FP multiplier.
- Multicycle and iterative, unlike the pipelined multiplier: operands are unpacked at start, the 24-bit mantissas go through a restoring division with guard, round and sticky bits, then the result is rounded and packed.
- Start/busy/done handshake. One operation in flight at a time.

---
 rtl/fdiv_pkg.sv | 20 ++
 rtl/fdiv_mant_step.sv | 20 ++
 rtl/float_div_iter.sv | 185 ++++++++++++++++++
 tb/tb_float_div_iter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fdiv_pkg.sv
// Shared types and constants for the iterative single-precision divider.
package fdiv_pkg;

  typedef enum logic [1:0] {IDLE, DIV, ROUND, FIN} state_t;
  typedef enum logic [1:0] {ZERO, NORM, INF, NAN} fclass_t;

  localparam int          BIAS    = 127;
  localparam int          EXP_MAX = 255;
  localparam int          QBITS   = 26;
  localparam logic [31:0] QNAN    = 32'h7FC00000;
  localparam logic [31:0] POS_INF = 32'h7F800000;

  // Zero and denormal encodings both classify as ZERO (flush-to-zero).
  function automatic fclass_t classify(input logic [7:0] e, input logic [22:0] f);
    if (e == 8'd0)       return ZERO;
    else if (e == 8'hFF) return (f == '0) ? INF : NAN;
    else                 return NORM;
  endfunction

endpackage

// File: rtl/fdiv_mant_step.sv
// One restoring division step: subtract divisor if it fits, then shift left.
module fdiv_mant_step
  import fdiv_pkg::*;
(
  input  logic [24:0] i_rem,
  input  logic [23:0] i_div,
  output logic [24:0] o_rem,
  output logic        o_q
);

  logic [25:0] w_diff;

  always_comb begin
    w_diff = {1'b0, i_rem} - {2'b00, i_div};
    o_q    = ~w_diff[25];
    // Whichever branch is kept is already below the divisor, so bit 24 is free for the shift.
    o_rem  = o_q ? {w_diff[23:0], 1'b0} : {i_rem[23:0], 1'b0};
  end

endmodule

// File: rtl/float_div_iter.sv
// Iterative IEEE-754 single-precision divider with start/busy/done handshake.
// Optional build macro FDIV_RADIX4_EN retires two quotient bits per DIV cycle.
module float_div_iter
  import fdiv_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic [31:0] input_a,
  input  logic [31:0] input_b,
  output logic        busy,
  output logic [31:0] output_z,
  output logic        exception,
  output logic        done
);

`ifdef FDIV_RADIX4_EN
  localparam logic [4:0] LAST_CNT = 5'(QBITS / 2 - 1);
`else
  localparam logic [4:0] LAST_CNT = 5'(QBITS - 1);
`endif
  localparam logic [9:0]        BIAS10  = 10'(BIAS);
  localparam logic signed [9:0] EXP_LIM = 10'(EXP_MAX);

  state_t            r_state, w_next;
  logic [24:0]       r_rem;
  logic [23:0]       r_div;
  logic [QBITS-1:0]  r_q;
  logic signed [9:0] r_exp;
  logic              r_sign, r_special, r_exc;
  logic [31:0]       r_res;
  logic [4:0]        r_cnt;

  fclass_t           w_ca, w_cb;
  logic              w_sign, w_special, w_sexc, w_lt;
  logic [31:0]       w_sres;
  logic [23:0]       w_ma, w_mb;
  logic [24:0]       w_rem0;
  logic [9:0]        w_exp_base;
  logic signed [9:0] w_exp0, w_exp_r;
  logic              w_up, w_rexc;
  logic [24:0]       w_mant;
  logic [22:0]       w_frac;
  logic [31:0]       w_rres;
  logic [24:0]       w_rem1;
  logic              w_q1;

  fdiv_mant_step u_step0 (.i_rem(r_rem), .i_div(r_div), .o_rem(w_rem1), .o_q(w_q1));

`ifdef FDIV_RADIX4_EN
  logic [24:0] w_rem2;
  logic        w_q2;
  fdiv_mant_step u_step1 (.i_rem(w_rem1), .i_div(r_div), .o_rem(w_rem2), .o_q(w_q2));
`endif

  // Operand classification and special-case result, in priority order.
  always_comb begin
    w_ca      = classify(input_a[30:23], input_a[22:0]);
    w_cb      = classify(input_b[30:23], input_b[22:0]);
    w_sign    = input_a[31] ^ input_b[31];
    w_special = 1'b1;
    w_sres    = '0;
    w_sexc    = 1'b0;
    if (w_ca == NAN)
      w_sres = input_a | 32'h0040_0000;
    else if (w_cb == NAN)
      w_sres = input_b | 32'h0040_0000;
    else if ((w_ca == ZERO && w_cb == ZERO) || (w_ca == INF && w_cb == INF)) begin
      w_sres = QNAN;
      w_sexc = 1'b1;
    end
    else if (w_ca == INF)
      w_sres = {w_sign, POS_INF[30:0]};
    else if (w_cb == INF)
      w_sres = {w_sign, 31'd0};
    else if (w_ca == ZERO)
      w_sres = {w_sign, 31'd0};
    else if (w_cb == ZERO) begin
      w_sres = {w_sign, POS_INF[30:0]};
      w_sexc = 1'b1;
    end
    else
      w_special = 1'b0;
  end

  // Pre-normalise so the quotient lands in [1,2).
  always_comb begin
    w_ma       = {1'b1, input_a[22:0]};
    w_mb       = {1'b1, input_b[22:0]};
    w_lt       = (w_ma < w_mb);
    w_exp_base = {2'b00, input_a[30:23]} - {2'b00, input_b[30:23]} + BIAS10;
    w_exp0     = w_lt ? (w_exp_base - 10'sd1) : w_exp_base;
    w_rem0     = w_lt ? {w_ma, 1'b0} : {1'b0, w_ma};
  end

  // Round to nearest even on q = {24 mantissa bits, guard, round} plus sticky.
  always_comb begin
    w_up    = r_q[1] & (r_q[0] | (|r_rem) | r_q[2]);
    w_mant  = {1'b0, r_q[QBITS-1:2]} + {24'd0, w_up};
    w_exp_r = r_exp + (w_mant[24] ? 10'sd1 : 10'sd0);
    w_frac  = w_mant[24] ? w_mant[23:1] : w_mant[22:0];
    w_rexc  = 1'b0;
    if (w_exp_r >= EXP_LIM) begin
      w_rres = {r_sign, POS_INF[30:0]};
      w_rexc = 1'b1;
    end
    else if (w_exp_r <= 10'sd0)
      w_rres = {r_sign, 31'd0};
    else
      w_rres = {r_sign, w_exp_r[7:0], w_frac};
  end

  always_ff @(posedge clk) begin
    if (clr) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Special operands also pass through ROUND, which leaves their result untouched.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = w_special ? ROUND : DIV;
      DIV:     if (r_cnt == LAST_CNT) w_next = ROUND;
      ROUND:   w_next = FIN;
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      output_z  <= '0;
      exception <= 1'b0;
      done      <= 1'b0;
      r_rem     <= '0;
      r_div     <= '0;
      r_q       <= '0;
      r_exp     <= '0;
      r_sign    <= 1'b0;
      r_special <= 1'b0;
      r_exc     <= 1'b0;
      r_res     <= '0;
      r_cnt     <= '0;
    end
    else begin
      done <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_sign    <= w_sign;
          r_special <= w_special;
          r_res     <= w_sres;
          r_exc     <= w_sexc;
          r_div     <= w_mb;
          r_rem     <= w_rem0;
          r_exp     <= w_exp0;
          r_q       <= '0;
          r_cnt     <= '0;
        end
        DIV: begin
`ifdef FDIV_RADIX4_EN
          r_rem <= w_rem2;
          r_q   <= {r_q[QBITS-3:0], w_q1, w_q2};
`else
          r_rem <= w_rem1;
          r_q   <= {r_q[QBITS-2:0], w_q1};
`endif
          r_cnt <= r_cnt + 5'd1;
        end
        ROUND: if (!r_special) begin
          r_res <= w_rres;
          r_exc <= w_rexc;
        end
        FIN: begin
          output_z  <= r_res;
          exception <= r_exc;
          done      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state != IDLE);

endmodule

// File: tb/tb_float_div_iter.sv
// Self-checking bench for float_div_iter: scoreboard of constant expected results.
module tb_float_div_iter;

`ifdef FDIV_RADIX4_EN
  localparam int LAT = 15;
`else
  localparam int LAT = 28;
`endif
  localparam int SLAT = 2;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] z;
    logic        e;
    logic        sp;
  } vec_t;

  logic        clk = 1'b0;
  logic        clr, start;
  logic [31:0] input_a, input_b;
  logic        busy, exception, done;
  logic [31:0] output_z;

  int          checks = 0;
  int          fails  = 0;
  logic [32:0] exp_q[$];

  float_div_iter dut (
    .clk(clk), .clr(clr), .start(start), .input_a(input_a), .input_b(input_b),
    .busy(busy), .output_z(output_z), .exception(exception), .done(done)
  );

  always #5 clk = ~clk;

  task automatic issue(input vec_t v);
    @(negedge clk);
    input_a = v.a;
    input_b = v.b;
    start   = 1'b1;
    exp_q.push_back({v.e, v.z});
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int lat);
    lat = -1;
    for (int n = 1; n <= budget; n++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    clr = 1'b1; start = 1'b0; input_a = '0; input_b = '0;
    repeat (2) @(posedge clk);
    #1 clr = 1'b0;
    checks++;
    if (busy !== 1'b0 || output_z !== 32'd0 || exception !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset: busy=%b z=%h exc=%b done=%b required 0/00000000/0/0",
               busy, output_z, exception, done);
    end
  endtask

  task automatic test_normal();
    vec_t v[8] = '{
      '{32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0},
      '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0, 1'b0},
      '{32'hC0F00000, 32'h40200000, 32'hC0400000, 1'b0, 1'b0},
      '{32'hBF800000, 32'h40000000, 32'hBF000000, 1'b0, 1'b0},
      '{32'h42C80000, 32'h41200000, 32'h41200000, 1'b0, 1'b0},
      '{32'h3F800000, 32'h41200000, 32'h3DCCCCCD, 1'b0, 1'b0},
      '{32'h40000000, 32'h40400000, 32'h3F2AAAAB, 1'b0, 1'b0},
      '{32'h3F800000, 32'h40E00000, 32'h3E124925, 1'b0, 1'b0}};
    int lat;
    logic [32:0] ex;
    foreach (v[i]) begin
      issue(v[i]);
      wait_done(LAT + 10, lat);
      ex = exp_q.pop_front();
      checks++;
      if (lat != LAT) begin
        fails++;
        $display("FAIL normal_lat[%0d]: got %0d required %0d", i, lat, LAT);
      end
      checks++;
      if (output_z !== ex[31:0] || exception !== ex[32]) begin
        fails++;
        $display("FAIL normal[%0d] %h/%h: got %h exc=%b required %h exc=%b",
                 i, v[i].a, v[i].b, output_z, exception, ex[31:0], ex[32]);
      end
    end
  endtask

  task automatic test_special();
    vec_t v[12] = '{
      '{32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1, 1'b1},
      '{32'h00000000, 32'h80000000, 32'h7FC00000, 1'b1, 1'b1},
      '{32'h7FA00000, 32'h3F800000, 32'h7FE00000, 1'b0, 1'b1},
      '{32'h3F800000, 32'h7F800001, 32'h7FC00001, 1'b0, 1'b1},
      '{32'h7F800001, 32'h7FA00000, 32'h7FC00001, 1'b0, 1'b1},
      '{32'h7F800000, 32'hFF800000, 32'h7FC00000, 1'b1, 1'b1},
      '{32'hFF800000, 32'h40000000, 32'hFF800000, 1'b0, 1'b1},
      '{32'hFF800000, 32'h00000000, 32'hFF800000, 1'b0, 1'b1},
      '{32'hC0000000, 32'h7F800000, 32'h80000000, 1'b0, 1'b1},
      '{32'h80000000, 32'h40000000, 32'h80000000, 1'b0, 1'b1},
      '{32'h00000001, 32'h3F800000, 32'h00000000, 1'b0, 1'b1},
      '{32'hBF800000, 32'h00000005, 32'hFF800000, 1'b1, 1'b1}};
    int lat;
    logic [32:0] ex;
    foreach (v[i]) begin
      issue(v[i]);
      wait_done(LAT + 10, lat);
      ex = exp_q.pop_front();
      checks++;
      if (lat != SLAT) begin
        fails++;
        $display("FAIL special_lat[%0d]: got %0d required %0d", i, lat, SLAT);
      end
      checks++;
      if (output_z !== ex[31:0] || exception !== ex[32]) begin
        fails++;
        $display("FAIL special[%0d] %h/%h: got %h exc=%b required %h exc=%b",
                 i, v[i].a, v[i].b, output_z, exception, ex[31:0], ex[32]);
      end
    end
  endtask

  task automatic test_range();
    vec_t v[6] = '{
      '{32'h7F000000, 32'h3E800000, 32'h7F800000, 1'b1, 1'b0},
      '{32'h7F000000, 32'h3F000000, 32'h7F800000, 1'b1, 1'b0},
      '{32'h7E800000, 32'h3F000000, 32'h7F000000, 1'b0, 1'b0},
      '{32'h00800000, 32'h40000000, 32'h00000000, 1'b0, 1'b0},
      '{32'h80800000, 32'h40000000, 32'h80000000, 1'b0, 1'b0},
      '{32'h01000000, 32'h40000000, 32'h00800000, 1'b0, 1'b0}};
    int lat;
    logic [32:0] ex;
    foreach (v[i]) begin
      issue(v[i]);
      wait_done(LAT + 10, lat);
      ex = exp_q.pop_front();
      checks++;
      if (output_z !== ex[31:0] || exception !== ex[32] || lat != LAT) begin
        fails++;
        $display("FAIL range[%0d] %h/%h: got %h exc=%b lat=%0d required %h exc=%b lat=%0d",
                 i, v[i].a, v[i].b, output_z, exception, lat, ex[31:0], ex[32], LAT);
      end
    end
  endtask

  task automatic test_ignore_start();
    vec_t first = '{32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0};
    vec_t after = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0, 1'b0};
    int lat;
    int extra;
    logic [32:0] ex;
    issue(first);
    repeat (4) @(posedge clk);
    @(negedge clk);
    input_a = 32'h3F800000;
    input_b = 32'h00000000;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL ignore_busy: got %b required 1", busy);
    end
    wait_done(LAT + 10, lat);
    ex = exp_q.pop_front();
    checks++;
    if (output_z !== ex[31:0] || exception !== ex[32] || lat != LAT - 5) begin
      fails++;
      $display("FAIL ignore_result: got %h exc=%b lat=%0d required %h exc=0 lat=%0d",
               output_z, exception, lat, ex[31:0], LAT - 5);
    end
    extra = 0;
    for (int n = 0; n < 35; n++) begin
      @(posedge clk); #1;
      if (done === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin
      fails++;
      $display("FAIL ignore_no_second_done: got %0d pulses required 0", extra);
    end
    issue(after);
    wait_done(LAT + 10, lat);
    ex = exp_q.pop_front();
    checks++;
    if (output_z !== ex[31:0] || exception !== ex[32] || lat != LAT) begin
      fails++;
      $display("FAIL ignore_next: got %h lat=%0d required %h lat=%0d", output_z, lat, ex[31:0], LAT);
    end
  endtask

  task automatic test_clr_midway();
    vec_t v1 = '{32'hC0F00000, 32'h40200000, 32'hC0400000, 1'b0, 1'b0};
    vec_t v2 = '{32'h40000000, 32'h40400000, 32'h3F2AAAAB, 1'b0, 1'b0};
    int lat;
    int pulses;
    logic [32:0] ex;
    issue(v1);
    repeat (9) @(posedge clk);
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    void'(exp_q.pop_front());
    checks++;
    if (busy !== 1'b0 || output_z !== 32'd0 || exception !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL clr_state: busy=%b z=%h exc=%b done=%b required 0/00000000/0/0",
               busy, output_z, exception, done);
    end
    pulses = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (done === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      fails++;
      $display("FAIL clr_no_done: got %0d pulses required 0", pulses);
    end
    issue(v2);
    wait_done(LAT + 10, lat);
    ex = exp_q.pop_front();
    checks++;
    if (output_z !== ex[31:0] || exception !== ex[32] || lat != LAT) begin
      fails++;
      $display("FAIL clr_after: got %h lat=%0d required %h lat=%0d", output_z, lat, ex[31:0], LAT);
    end
  endtask

  task automatic test_back_to_back();
    vec_t v[4] = '{
      '{32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0},
      '{32'h41100000, 32'h40400000, 32'h40400000, 1'b0, 1'b0},
      '{32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1, 1'b1},
      '{32'hBF800000, 32'h40400000, 32'hBEAAAAAB, 1'b0, 1'b0}};
    int lat;
    logic [32:0] ex;
    foreach (v[i]) begin
      issue(v[i]);
      wait_done(LAT + 10, lat);
      ex = exp_q.pop_front();
      checks++;
      if (output_z !== ex[31:0] || exception !== ex[32] || lat != (v[i].sp ? SLAT : LAT)) begin
        fails++;
        $display("FAIL b2b[%0d]: got %h exc=%b lat=%0d required %h exc=%b lat=%0d",
                 i, output_z, exception, lat, ex[31:0], ex[32], v[i].sp ? SLAT : LAT);
      end
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_special();
    test_range();
    test_ignore_start();
    test_clr_midway();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
